// File: rtl/lenet_pkg.sv
// Shared types and helpers for the LeNet convolution datapath.
// Holds the sequencer FSM encoding and output-size helpers for the default
// 32x32 / 5x5 layer.
package lenet_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam int IMG_W_DEF = 32;
    localparam int IMG_H_DEF = 32;
    localparam int K_DEF     = 5;

    // Output map size for stride 1, no padding, at the default geometry.
    localparam int OUT_W = IMG_W_DEF - K_DEF + 1;
    localparam int OUT_H = IMG_H_DEF - K_DEF + 1;
    localparam int KK    = K_DEF * K_DEF;

    // Output dimension for a given input dimension and kernel size.
    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_seq_counter.sv
// Wrap counter used as one stage of the kx/ky/ox/oy loop chain.
// wrap is combinational so the next stage can advance in the same cycle.
module conv_seq_counter
    import lenet_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = en && (count == max);

    // Count on enable, returning to zero after max; clr restarts the loop.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Convolution layer pass sequencer: walks kx, ky, ox, oy (innermost first),
// issues feature-map/weight read addresses and drives MAC control aligned
// to one-cycle SRAM read latency.
// Optional: define CONV_SEQ_PERF_EN to add the stall_cnt performance counter.
module conv_loop_sequencer
    import lenet_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int K       = K_DEF,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  fm_addr,
    output logic [WADDR_W-1:0] wt_addr,
    output logic               mac_en,
    output logic               acc_clr,
    output logic               acc_last,
    output logic [ADDR_W-1:0]  out_addr
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int OW  = out_dim(IMG_W, K);
    localparam int OH  = out_dim(IMG_H, K);
    localparam int KXW = cnt_w(K);
    localparam int OXW = cnt_w(OW);
    localparam int OYW = cnt_w(OH);

    seq_state_e        state_q, state_d;
    logic              start_acc;
    logic [KXW-1:0]    kx_cnt, ky_cnt;
    logic [OXW-1:0]    ox_cnt;
    logic [OYW-1:0]    oy_cnt;
    logic              kx_wrap, ky_wrap, ox_wrap, oy_wrap;
    logic [ADDR_W-1:0] pix_base_q, row_base_q, out_cnt_q;
    logic [ADDR_W-1:0] pix_next, row_next;
    logic              tap_vld_q, tap_first_q, tap_last_q;
    logic              unused_cnt;

    assign start_acc = (state_q == IDLE) && start;

    // Output-pixel coordinates are tracked incrementally in pix_base/out_cnt;
    // ox/oy counts only feed the carry chain.
    assign unused_cnt = ^{ox_cnt, oy_cnt};

    conv_seq_counter #(.W(KXW)) u_kx (
        .clk(clk), .rst(rst), .clr(start_acc), .en(rd_en),
        .max(KXW'(K - 1)), .count(kx_cnt), .wrap(kx_wrap)
    );
    conv_seq_counter #(.W(KXW)) u_ky (
        .clk(clk), .rst(rst), .clr(start_acc), .en(kx_wrap),
        .max(KXW'(K - 1)), .count(ky_cnt), .wrap(ky_wrap)
    );
    conv_seq_counter #(.W(OXW)) u_ox (
        .clk(clk), .rst(rst), .clr(start_acc), .en(ky_wrap),
        .max(OXW'(OW - 1)), .count(ox_cnt), .wrap(ox_wrap)
    );
    conv_seq_counter #(.W(OYW)) u_oy (
        .clk(clk), .rst(rst), .clr(start_acc), .en(ox_wrap),
        .max(OYW'(OH - 1)), .count(oy_cnt), .wrap(oy_wrap)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; oy_wrap marks the final tap being issued.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        busy    = (state_q == RUN) || (state_q == DRAIN);
        done    = (state_q == DONE);
        rd_en   = (state_q == RUN) && !stall;
        case (state_q)
            IDLE:    if (start)   state_d = RUN;
            RUN:     if (oy_wrap) state_d = DRAIN;
            DRAIN:   if (!stall)  state_d = DONE;
            DONE:                 state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Candidate bases: next output pixel (same row, or +K to skip the
    // kernel overhang into the next row) and next kernel row.
    always_comb begin
        pix_next = pix_base_q + (ox_wrap ? ADDR_W'(K) : ADDR_W'(1));
        row_next = row_base_q + ADDR_W'(IMG_W);
    end

    // Incremental address generation; registers hold while rd_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_base_q <= '0;
            row_base_q <= '0;
            fm_addr    <= '0;
            wt_addr    <= '0;
            out_cnt_q  <= '0;
        end else if (start_acc || (rd_en && oy_wrap)) begin
            pix_base_q <= '0;
            row_base_q <= '0;
            fm_addr    <= '0;
            wt_addr    <= '0;
            out_cnt_q  <= '0;
        end else if (rd_en) begin
            if (ky_wrap) begin
                pix_base_q <= pix_next;
                row_base_q <= pix_next;
                fm_addr    <= pix_next;
                wt_addr    <= '0;
                out_cnt_q  <= out_cnt_q + 1'b1;
            end else if (kx_wrap) begin
                row_base_q <= row_next;
                fm_addr    <= row_next;
                wt_addr    <= wt_addr + 1'b1;
            end else begin
                fm_addr    <= fm_addr + 1'b1;
                wt_addr    <= wt_addr + 1'b1;
            end
        end
    end

    // One-stage tap pipeline matching the SRAM read latency; frozen on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_vld_q   <= 1'b0;
            tap_first_q <= 1'b0;
            tap_last_q  <= 1'b0;
            out_addr    <= '0;
        end else if (!stall) begin
            tap_vld_q   <= rd_en;
            tap_first_q <= rd_en && (kx_cnt == '0) && (ky_cnt == '0);
            tap_last_q  <= ky_wrap;
            out_addr    <= out_cnt_q;
        end
    end

    assign mac_en   = tap_vld_q && !stall;
    assign acc_clr  = mac_en && tap_first_q;
    assign acc_last = mac_en && tap_last_q;

`ifdef CONV_SEQ_PERF_EN
    // Saturating count of stalled busy cycles, cleared when a pass starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if (busy && stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Self-checking bench for conv_loop_sequencer: a 6x6/K=3 instance and a
// 4x4/K=1 instance, checked against a tap list built from nested loops.
`timescale 1ns/1ps
module tb_conv_loop_sequencer;

    typedef struct {
        int fm;
        int wt;
        bit first;
        bit last;
        int out;
    } tap_t;

    typedef struct {
        bit start;
        bit stall;
        bit busy;
        bit done;
        bit rd_en;
        int fm;
        int wt;
        bit mac_en;
        bit clr;
        bit last;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst[2];
    logic       start[2];
    logic       stall[2];
    logic       busy[2], done[2], rd_en[2], mac_en[2], acc_clr[2], acc_last[2];
    logic [9:0] fm_addr[2], out_addr[2];
    logic [4:0] wt_addr[2];
`ifdef CONV_SEQ_PERF_EN
    logic [15:0] stall_cnt[2];
`endif

    conv_loop_sequencer #(.IMG_W(6), .IMG_H(6), .K(3), .ADDR_W(10), .WADDR_W(5)) dut_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .stall(stall[0]),
        .busy(busy[0]), .done(done[0]), .rd_en(rd_en[0]),
        .fm_addr(fm_addr[0]), .wt_addr(wt_addr[0]),
        .mac_en(mac_en[0]), .acc_clr(acc_clr[0]), .acc_last(acc_last[0]),
        .out_addr(out_addr[0])
`ifdef CONV_SEQ_PERF_EN
        , .stall_cnt(stall_cnt[0])
`endif
    );

    conv_loop_sequencer #(.IMG_W(4), .IMG_H(4), .K(1), .ADDR_W(10), .WADDR_W(5)) dut_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .stall(stall[1]),
        .busy(busy[1]), .done(done[1]), .rd_en(rd_en[1]),
        .fm_addr(fm_addr[1]), .wt_addr(wt_addr[1]),
        .mac_en(mac_en[1]), .acc_clr(acc_clr[1]), .acc_last(acc_last[1]),
        .out_addr(out_addr[1])
`ifdef CONV_SEQ_PERF_EN
        , .stall_cnt(stall_cnt[1])
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    tap_t exp_tap[2][144];
    int   n_taps[2], n_pix[2];
    int   rd_idx[2], mac_idx[2], clr_cnt[2], last_cnt[2];
    int   done_cnt[2], busy_stall[2], start_cyc[2], done_cyc[2];
    vec_t snap;
    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference tap order straight from the loop nest: oy, ox, ky, kx.
    task automatic build_model(input int d, input int w, input int h, input int k);
        int n = 0;
        int ow = w - k + 1;
        int oh = h - k + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        exp_tap[d][n].fm    = (oy + ky) * w + (ox + kx);
                        exp_tap[d][n].wt    = ky * k + kx;
                        exp_tap[d][n].first = (kx == 0) && (ky == 0);
                        exp_tap[d][n].last  = (kx == k - 1) && (ky == k - 1);
                        exp_tap[d][n].out   = oy * ow + ox;
                        n++;
                    end
        n_taps[d] = n;
        n_pix[d]  = ow * oh;
    endtask

    function automatic vec_t mk(input bit st, input bit sl, input bit b, input bit dn,
                                input bit rd, input int fm, input int wt,
                                input bit me, input bit cl, input bit la);
        vec_t v;
        v.start = st; v.stall = sl; v.busy = b; v.done = dn; v.rd_en = rd;
        v.fm = fm; v.wt = wt; v.mac_en = me; v.clr = cl; v.last = la;
        return v;
    endfunction

    task automatic begin_pass(input int d);
        rd_idx[d] = 0; mac_idx[d] = 0; clr_cnt[d] = 0; last_cnt[d] = 0;
        done_cnt[d] = 0; busy_stall[d] = 0; done_cyc[d] = -1;
        start_cyc[d] = cyc;
    endtask

    // One clock cycle: sample both DUTs mid-cycle and score against the model.
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rd_en[d]) begin
                if (rd_idx[d] < n_taps[d]) begin
                    check("fm_addr", int'(fm_addr[d]), exp_tap[d][rd_idx[d]].fm);
                    check("wt_addr", int'(wt_addr[d]), exp_tap[d][rd_idx[d]].wt);
                end else begin
                    check("rd_en_count", rd_idx[d] + 1, n_taps[d]);
                end
                rd_idx[d]++;
            end else if (busy[d] && stall[d] && rd_idx[d] < n_taps[d]) begin
                check("fm_addr_held", int'(fm_addr[d]), exp_tap[d][rd_idx[d]].fm);
                check("wt_addr_held", int'(wt_addr[d]), exp_tap[d][rd_idx[d]].wt);
            end
            if (stall[d]) check("mac_en_in_stall", int'(mac_en[d]), 0);
            if (mac_en[d]) begin
                if (mac_idx[d] < n_taps[d]) begin
                    check("acc_clr", int'(acc_clr[d]), int'(exp_tap[d][mac_idx[d]].first));
                    check("acc_last", int'(acc_last[d]), int'(exp_tap[d][mac_idx[d]].last));
                    if (exp_tap[d][mac_idx[d]].last)
                        check("out_addr", int'(out_addr[d]), exp_tap[d][mac_idx[d]].out);
                end else begin
                    check("mac_en_count", mac_idx[d] + 1, n_taps[d]);
                end
                clr_cnt[d]  += int'(acc_clr[d]);
                last_cnt[d] += int'(acc_last[d]);
                mac_idx[d]++;
                check("mac_lags_rd", (mac_idx[d] <= rd_idx[d]) ? 1 : 0, 1);
            end else begin
                check("acc_flags_without_mac", int'(acc_clr[d] | acc_last[d]), 0);
            end
            if (done[d]) begin
                done_cnt[d]++;
                done_cyc[d] = cyc;
            end
            if (busy[d] && stall[d]) busy_stall[d]++;
        end
        snap.busy = busy[0]; snap.done = done[0]; snap.rd_en = rd_en[0];
        snap.fm = int'(fm_addr[0]); snap.wt = int'(wt_addr[0]);
        snap.mac_en = mac_en[0]; snap.clr = acc_clr[0]; snap.last = acc_last[0];
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic end_pass(input int d);
        check("rd_total", rd_idx[d], n_taps[d]);
        check("mac_total", mac_idx[d], n_taps[d]);
        check("acc_clr_total", clr_cnt[d], n_pix[d]);
        check("acc_last_total", last_cnt[d], n_pix[d]);
        check("done_pulses", done_cnt[d], 1);
        check("done_cycle", done_cyc[d], start_cyc[d] + n_taps[d] + 2 + busy_stall[d]);
`ifdef CONV_SEQ_PERF_EN
        check("stall_cnt", int'(stall_cnt[d]), busy_stall[d]);
`endif
    endtask

    // Run the pass already started on DUT d to completion.
    // pct: random stall percentage; poke: spurious starts in RUN and DONE;
    // stall_at/stall_len: directed RUN stall; drain_len: directed DRAIN stall.
    task automatic finish_pass(input int d, input int pct, input bit poke,
                               input int stall_at, input int stall_len, input int drain_len);
        int left_run   = stall_len;
        int left_drain = drain_len;
        bit sl, st;
        for (int budget = 0; budget < 2000 && done_cnt[d] == 0; budget++) begin
            sl = ($urandom_range(99) < pct);
            st = 1'b0;
            if (left_run > 0 && rd_idx[d] == stall_at) begin
                sl = 1'b1;
                left_run--;
            end
            if (left_drain > 0 && rd_idx[d] == n_taps[d] && mac_idx[d] < n_taps[d]) begin
                sl = 1'b1;
                left_drain--;
            end
            if (poke && rd_idx[d] < n_taps[d] && $urandom_range(7) == 0) st = 1'b1;
            if (poke && mac_idx[d] == n_taps[d]) st = 1'b1;
            start[d] = st;
            stall[d] = sl;
            step();
        end
        start[d] = 1'b0;
        stall[d] = 1'b0;
        step();
        step();
        check("idle_after_pass", int'(busy[d]), 0);
        end_pass(d);
    endtask

    task automatic run_pass(input int d, input int pct, input bit poke,
                            input int stall_at, input int stall_len, input int drain_len);
        begin_pass(d);
        start[d] = 1'b1;
        stall[d] = 1'b0;
        step();
        start[d] = 1'b0;
        finish_pass(d, pct, poke, stall_at, stall_len, drain_len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; stall[d] = 1'b0;
        end
        build_model(0, 6, 6, 3);
        build_model(1, 4, 4, 1);
        for (int d = 0; d < 2; d++) begin_pass(d);

        // Cycle-by-cycle opening of a 6x6/K=3 pass, including a stall and an
        // ignored start.
        tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2] = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[3] = mk(0, 0, 1, 0, 1, 1, 1, 1, 1, 0);
        tbl[4] = mk(0, 1, 1, 0, 0, 2, 2, 0, 0, 0);
        tbl[5] = mk(0, 0, 1, 0, 1, 2, 2, 1, 0, 0);
        tbl[6] = mk(1, 0, 1, 0, 1, 6, 3, 1, 0, 0);
        tbl[7] = mk(0, 0, 1, 0, 1, 7, 4, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy_b", int'(busy[1]), 0);
        check("reset_fm_b", int'(fm_addr[1]), 0);
        check("reset_out_b", int'(out_addr[1]), 0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin_pass(0);
            start[0] = tbl[i].start;
            stall[0] = tbl[i].stall;
            step();
            check("tbl_busy", int'(snap.busy), int'(tbl[i].busy));
            check("tbl_done", int'(snap.done), int'(tbl[i].done));
            check("tbl_rd_en", int'(snap.rd_en), int'(tbl[i].rd_en));
            check("tbl_fm_addr", snap.fm, tbl[i].fm);
            check("tbl_wt_addr", snap.wt, tbl[i].wt);
            check("tbl_mac_en", int'(snap.mac_en), int'(tbl[i].mac_en));
            check("tbl_acc_clr", int'(snap.clr), int'(tbl[i].clr));
            check("tbl_acc_last", int'(snap.last), int'(tbl[i].last));
        end
        start[0] = 1'b0;
        finish_pass(0, 0, 1'b0, -1, 0, 0);

        // K=1: every tap is both first and last; done 18 cycles after start.
        run_pass(1, 0, 1'b0, -1, 0, 0);
        check("k1_done_latency", done_cyc[1] - start_cyc[1], 18);

        // Three-cycle stall mid-RUN plus two in DRAIN.
        run_pass(0, 0, 1'b0, 20, 3, 2);
        check("stall_cycles", busy_stall[0], 5);
        check("stalled_done_latency", done_cyc[0] - start_cyc[0], 144 + 2 + 5);

        // Spurious starts in RUN and DONE, then a fresh pass from IDLE.
        run_pass(0, 0, 1'b1, -1, 0, 0);
        run_pass(0, 0, 1'b0, -1, 0, 0);

        // Asynchronous reset at tap 50 abandons the pass.
        begin_pass(0);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int i = 0; i < 200 && rd_idx[0] < 50; i++) step();
        #2 rst[0] = 1'b1;
        #1;
        check("rst_busy", int'(busy[0]), 0);
        check("rst_done", int'(done[0]), 0);
        check("rst_rd_en", int'(rd_en[0]), 0);
        check("rst_fm_addr", int'(fm_addr[0]), 0);
        check("rst_wt_addr", int'(wt_addr[0]), 0);
        check("rst_mac_en", int'(mac_en[0]), 0);
        check("rst_acc_clr", int'(acc_clr[0]), 0);
        check("rst_acc_last", int'(acc_last[0]), 0);
        check("rst_out_addr", int'(out_addr[0]), 0);
        step();
        step();
        rst[0] = 1'b0;
        repeat (4) step();
        check("no_done_after_rst", done_cnt[0], 0);
        check("idle_after_rst", int'(busy[0]), 0);
        run_pass(0, 0, 1'b0, -1, 0, 0);

        // Random stalls and spurious starts on both geometries.
        for (int r = 0; r < 3; r++) begin
            run_pass(0, 25, 1'b1, -1, 0, 0);
            run_pass(1, 30, 1'b1, -1, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
